// File: rtl/serial_rx_engine_pkg.sv
// serial_rx_engine_pkg
//   Shared definitions for the EMC08 serial receive path. The package holds
//   the receive FSM state encoding, the mode constants shared with the TX
//   engine, and small helpers for the oversampling vote.
//   No ports; imported with "import serial_rx_engine_pkg::*".
package serial_rx_engine_pkg;

  // Receive FSM states, also exported on the debug state field of the bus.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_NINTH = 3'd3,
    ST_STOP  = 3'd4,
    ST_LOAD  = 3'd5
  } rx_state_e;

  // Frame format selected by nine_bit (shared with the TX engine).
  localparam logic MODE_8BIT = 1'b0;  // mode 1: rb8 carries the stop bit
  localparam logic MODE_9BIT = 1'b1;  // modes 2/3: rb8 carries the 9th bit

  // Tick index of the k-th vote sample (k = 0..2) centred on ovs/2.
  function automatic int unsigned vote_idx(input int unsigned ovs, input int unsigned k);
    return (ovs / 2) - 1 + k;
  endfunction

  // Two-out-of-three majority used to reject single-tick glitches.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_engine_if.sv
// serial_rx_engine_if
//   Groups the receive engine's line-side and CPU-side signals.
//   master modport: baud/RXD/SCON source and SBUF consumer (the environment).
//   slave modport : the receive engine itself.
//   Signals:
//     serial_br_tick_i, serial_rxd_i, serial_ren_i, serial_nine_bit_i,
//     serial_sm2_i, serial_rd_i                         -> into the engine
//     serial_data_o, serial_rb8_o, serial_ri_set_o, serial_fe_o,
//     serial_ovr_o, serial_busy_o, serial_valid_o, dbg_state_o -> out of the engine
//   Handshake: serial_valid_o says a head entry is present; serial_rd_i is the
//   consumer's one-cycle pop strobe. An entry is consumed on a clock where
//   rd=1 and valid=1; rd with valid=0 changes no storage but still clears the
//   sticky fe/ovr flags.
interface serial_rx_engine_if #(
  parameter int DATA_W = 8
);
  logic              serial_br_tick_i;
  logic              serial_rxd_i;
  logic              serial_ren_i;
  logic              serial_nine_bit_i;
  logic              serial_sm2_i;
  logic              serial_rd_i;
  logic [DATA_W-1:0] serial_data_o;
  logic              serial_rb8_o;
  logic              serial_ri_set_o;
  logic              serial_fe_o;
  logic              serial_ovr_o;
  logic              serial_busy_o;
  logic              serial_valid_o;
  logic [2:0]        dbg_state_o;

  modport master (
    output serial_br_tick_i, serial_rxd_i, serial_ren_i, serial_nine_bit_i,
           serial_sm2_i, serial_rd_i,
    input  serial_data_o, serial_rb8_o, serial_ri_set_o, serial_fe_o,
           serial_ovr_o, serial_busy_o, serial_valid_o, dbg_state_o
  );

  modport slave (
    input  serial_br_tick_i, serial_rxd_i, serial_ren_i, serial_nine_bit_i,
           serial_sm2_i, serial_rd_i,
    output serial_data_o, serial_rb8_o, serial_ri_set_o, serial_fe_o,
           serial_ovr_o, serial_busy_o, serial_valid_o, dbg_state_o
  );
endinterface

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo
//   Synchronous FIFO for received {rb8, data} entries. Pointers carry one
//   extra MSB so full and empty are told apart without a counter.
//   Ports:
//     clk_i, rst_i (async, active-high)
//     push_i / wdata_i : write an entry (accepted when not full, or when a
//                        pop happens in the same cycle)
//     pop_i            : drop the head entry (ignored when empty)
//     rdata_o          : head entry
//     full_o, empty_o  : occupancy flags
module serial_rx_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         pop_ok, push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot first, so a full FIFO can still take a write.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_rx_engine.sv
// serial_rx_engine
//   Asynchronous UART receive engine for the EMC08 serial port (modes 1/2/3).
//   RXD is oversampled on serial_br_tick_i (OVS ticks per bit); each bit is
//   the majority of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1, decided
//   on the last of them. Frames are start, DATA_W data bits LSB first, an
//   optional 9th bit, and a stop bit. SM2 filtering drops frames whose rb8
//   candidate is 0.
//   Ports:
//     serial_clock_i : system clock, rising edge
//     serial_reset_i : asynchronous reset, active-high
//     bus            : serial_rx_engine_if.slave (line inputs, SCON/SBUF side)
//   Build option:
//     SERIAL_RX_FIFO_EN defined   -> FIFO_DEPTH-entry receive FIFO
//     SERIAL_RX_FIFO_EN undefined -> single holding register (SBUF)
module serial_rx_engine
  import serial_rx_engine_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic              serial_clock_i,
  input logic              serial_reset_i,
  serial_rx_engine_if.slave bus
);
  localparam int TCW = $clog2(OVS);
  localparam int BCW = $clog2(DATA_W);

  localparam logic [TCW-1:0] V0     = TCW'(vote_idx(OVS, 0));
  localparam logic [TCW-1:0] V1     = TCW'(vote_idx(OVS, 1));
  localparam logic [TCW-1:0] V2     = TCW'(vote_idx(OVS, 2));
  localparam logic [TCW-1:0] T_LAST = TCW'(OVS - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(DATA_W - 1);

  if (OVS < 4 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("serial_rx_engine: OVS must be even and >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_rx_engine: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("serial_rx_engine: DATA_W must be 5..9");
  end

  rx_state_e         state_q, state_d;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]        samp_q, samp_d;
  logic              prev_rxd_q, prev_rxd_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              rb8_cand_q, rb8_cand_d;
  logic              stop_q, stop_d;
  logic              nine_q, nine_d;
  logic              sm2_q, sm2_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;

  logic tick_ok, vote, at_vote, at_end;
  logic in_load, accept, space, wr;

  // Ticks are ignored in LOAD so the one-cycle commit is never disturbed.
  assign tick_ok = bus.serial_br_tick_i && (state_q != ST_LOAD);
  assign vote    = majority3(samp_q[1], samp_q[0], bus.serial_rxd_i);
  assign at_vote = tick_ok && (tick_cnt_q == V2);
  assign at_end  = tick_ok && (tick_cnt_q == T_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    prev_rxd_d = prev_rxd_q;
    shreg_d    = shreg_q;
    rb8_cand_d = rb8_cand_q;
    stop_d     = stop_q;
    nine_d     = nine_q;
    sm2_d      = sm2_q;

    // prev_rxd holds the line value at the previous tick for edge detection.
    if (tick_ok) prev_rxd_d = bus.serial_rxd_i;

    if (state_q != ST_IDLE && tick_ok) begin
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == V0) samp_d[1] = bus.serial_rxd_i;
      if (tick_cnt_q == V1) samp_d[0] = bus.serial_rxd_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.serial_ren_i && tick_ok && prev_rxd_q && !bus.serial_rxd_i) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          // Mode and filter are frozen for the whole frame.
          nine_d     = bus.serial_nine_bit_i;
          sm2_d      = bus.serial_sm2_i;
        end
      end
      ST_START: begin
        if (at_vote && vote) state_d = ST_IDLE;  // glitch, not a start bit
        else if (at_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[DATA_W-1:1]};
        if (at_end) begin
          if (bit_cnt_q == B_LAST) state_d = (nine_q == MODE_9BIT) ? ST_NINTH : ST_STOP;
          else                     bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_NINTH: begin
        if (at_vote) rb8_cand_d = vote;
        if (at_end)  state_d    = ST_STOP;
      end
      ST_STOP: begin
        // Commit at the stop sample so a back-to-back start edge is not missed.
        if (at_vote) begin
          stop_d  = vote;
          if (nine_q == MODE_8BIT) rb8_cand_d = vote;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !bus.serial_ren_i) state_d = ST_IDLE;
  end

  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      prev_rxd_q <= 1'b0;
      shreg_q    <= '0;
      rb8_cand_q <= 1'b0;
      stop_q     <= 1'b0;
      nine_q     <= 1'b0;
      sm2_q      <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      prev_rxd_q <= prev_rxd_d;
      shreg_q    <= shreg_d;
      rb8_cand_q <= rb8_cand_d;
      stop_q     <= stop_d;
      nine_q     <= nine_d;
      sm2_q      <= sm2_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  // Commit: a LOAD cycle with ren still high. rd in the same cycle pops
  // first, so it counts as free space for this write.
  assign in_load = (state_q == ST_LOAD) && bus.serial_ren_i;
  assign accept  = !sm2_q || rb8_cand_q;
  assign wr      = in_load && accept && space;

  // Sticky flags: rd clears, a new event in the same cycle wins.
  always_comb begin
    fe_d  = bus.serial_rd_i ? 1'b0 : fe_q;
    ovr_d = bus.serial_rd_i ? 1'b0 : ovr_q;
    if (in_load && !stop_q)           fe_d  = 1'b1;
    if (in_load && accept && !space)  ovr_d = 1'b1;
  end

`ifdef SERIAL_RX_FIFO_EN
  logic [DATA_W:0] head;
  logic            full, empty;

  serial_rx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (serial_clock_i),
    .rst_i   (serial_reset_i),
    .push_i  (wr),
    .pop_i   (bus.serial_rd_i),
    .wdata_i ({rb8_cand_q, shreg_q}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign space              = !full || bus.serial_rd_i;
  assign bus.serial_data_o  = head[DATA_W-1:0];
  assign bus.serial_rb8_o   = head[DATA_W];
  assign bus.serial_valid_o = !empty;
`else
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_rb8_q;
  logic              valid_q;

  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      hold_data_q <= '0;
      hold_rb8_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else if (wr) begin
      hold_data_q <= shreg_q;
      hold_rb8_q  <= rb8_cand_q;
      valid_q     <= 1'b1;
    end else if (bus.serial_rd_i) begin
      hold_data_q <= '0;
      hold_rb8_q  <= 1'b0;
      valid_q     <= 1'b0;
    end
  end

  assign space              = !valid_q || bus.serial_rd_i;
  assign bus.serial_data_o  = hold_data_q;
  assign bus.serial_rb8_o   = hold_rb8_q;
  assign bus.serial_valid_o = valid_q;
`endif

  assign bus.serial_ri_set_o = wr;
  assign bus.serial_fe_o     = fe_q;
  assign bus.serial_ovr_o    = ovr_q;
  assign bus.serial_busy_o   = (state_q != ST_IDLE);
  assign bus.dbg_state_o     = state_q;

endmodule

// File: tb/tb_serial_rx_engine.sv
module tb_serial_rx_engine;
  localparam int DATA_W     = 8;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_rx_engine_if #(.DATA_W(DATA_W)) bus ();

  serial_rx_engine #(
    .DATA_W     (DATA_W),
    .OVS        (OVS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .serial_clock_i (clk),
    .serial_reset_i (rst),
    .bus            (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int ri_cnt   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Baud tick: one clock high out of every four.
  initial begin
    bus.serial_br_tick_i = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.serial_br_tick_i = 1'b1;
      @(negedge clk);
      bus.serial_br_tick_i = 1'b0;
    end
  end

  always @(negedge clk) if (bus.serial_ri_set_o === 1'b1) ri_cnt++;

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (bus.serial_br_tick_i !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.serial_rxd_i = b;
    wait_ticks(OVS);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use9, input logic b9,
                            input logic stop);
    bus.serial_nine_bit_i = use9;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    if (use9) send_bit(b9);
    send_bit(stop);
    bus.serial_rxd_i = 1'b1;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.serial_rd_i = 1'b1;
    @(negedge clk);
    bus.serial_rd_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [13:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bus.serial_busy_o, bus.serial_valid_o, bus.serial_ri_set_o, bus.serial_fe_o,
            bus.serial_ovr_o, bus.serial_rb8_o, bus.serial_data_o};
    checks++;
    if (outs !== 14'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", outs, 14'h0);
    end
    rst = 1'b0;
    wait_ticks(2);
    #1;
  endtask

  task automatic test_basic();
    int r0 = ri_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.serial_data_o !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", bus.serial_data_o); end
    checks++; if (bus.serial_rb8_o !== 1'b1) begin failures++; $display("FAIL basic_rb8 got=%b exp=1", bus.serial_rb8_o); end
    checks++; if (bus.serial_fe_o !== 1'b0) begin failures++; $display("FAIL basic_fe got=%b exp=0", bus.serial_fe_o); end
    checks++; if (bus.serial_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.serial_valid_o); end
    checks++; if (ri_cnt - r0 != 1) begin failures++; $display("FAIL basic_ri_pulses got=%0d exp=1", ri_cnt - r0); end
    checks++; if (bus.serial_busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bus.serial_busy_o); end
    pulse_rd();
    checks++; if (bus.serial_valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid_after_rd got=%b exp=0", bus.serial_valid_o); end
  endtask

  task automatic test_false_start();
    int r0 = ri_cnt;
    bus.serial_rxd_i = 1'b0;
    wait_ticks(4);
    #1;
    checks++; if (bus.serial_busy_o !== 1'b1) begin failures++; $display("FAIL fstart_busy_mid got=%b exp=1", bus.serial_busy_o); end
    bus.serial_rxd_i = 1'b1;
    wait_ticks(12);
    @(negedge clk);
    checks++; if (bus.serial_busy_o !== 1'b0) begin failures++; $display("FAIL fstart_busy_end got=%b exp=0", bus.serial_busy_o); end
    checks++; if (ri_cnt != r0) begin failures++; $display("FAIL fstart_ri got=%0d exp=0", ri_cnt - r0); end
    checks++; if (bus.serial_valid_o !== 1'b0) begin failures++; $display("FAIL fstart_valid got=%b exp=0", bus.serial_valid_o); end
  endtask

  task automatic test_framing();
    int r0 = ri_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.serial_data_o !== 8'h3C) begin failures++; $display("FAIL fe_data got=%h exp=3c", bus.serial_data_o); end
    checks++; if (bus.serial_fe_o !== 1'b1) begin failures++; $display("FAIL fe_flag got=%b exp=1", bus.serial_fe_o); end
    checks++; if (bus.serial_rb8_o !== 1'b0) begin failures++; $display("FAIL fe_rb8 got=%b exp=0", bus.serial_rb8_o); end
    checks++; if (ri_cnt - r0 != 1) begin failures++; $display("FAIL fe_ri got=%0d exp=1", ri_cnt - r0); end
    wait_ticks(8);
    @(negedge clk);
    checks++; if (bus.serial_fe_o !== 1'b1) begin failures++; $display("FAIL fe_sticky got=%b exp=1", bus.serial_fe_o); end
    pulse_rd();
    checks++; if (bus.serial_fe_o !== 1'b0) begin failures++; $display("FAIL fe_clear got=%b exp=0", bus.serial_fe_o); end
  endtask

  task automatic test_sm2();
    int r0;
    bus.serial_sm2_i = 1'b1;
    r0 = ri_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.serial_valid_o !== 1'b0) begin failures++; $display("FAIL sm2_reject_valid got=%b exp=0", bus.serial_valid_o); end
    checks++; if (ri_cnt != r0) begin failures++; $display("FAIL sm2_reject_ri got=%0d exp=0", ri_cnt - r0); end
    r0 = ri_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (bus.serial_valid_o !== 1'b1) begin failures++; $display("FAIL sm2_accept_valid got=%b exp=1", bus.serial_valid_o); end
    checks++; if (bus.serial_data_o !== 8'h55) begin failures++; $display("FAIL sm2_accept_data got=%h exp=55", bus.serial_data_o); end
    checks++; if (bus.serial_rb8_o !== 1'b1) begin failures++; $display("FAIL sm2_accept_rb8 got=%b exp=1", bus.serial_rb8_o); end
    checks++; if (ri_cnt - r0 != 1) begin failures++; $display("FAIL sm2_accept_ri got=%0d exp=1", ri_cnt - r0); end
    pulse_rd();
    bus.serial_sm2_i      = 1'b0;
    bus.serial_nine_bit_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int r0 = ri_cnt;
    logic [7:0] d;
    logic [7:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      d = 8'h11 + 8'(i);
      send_frame(d, 1'b0, 1'b0, 1'b1);
    end
`ifdef SERIAL_RX_FIFO_EN
    for (int i = 0; i < FIFO_DEPTH; i++) exp_q.push_back(8'h11 + 8'(i));
`else
    exp_q.push_back(8'h11);
`endif
    @(negedge clk);
    checks++; if (bus.serial_ovr_o !== 1'b1) begin failures++; $display("FAIL b2b_ovr got=%b exp=1", bus.serial_ovr_o); end
    checks++; if (ri_cnt - r0 != exp_q.size()) begin failures++; $display("FAIL b2b_ri got=%0d exp=%0d", ri_cnt - r0, exp_q.size()); end
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      checks++; if (bus.serial_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.serial_valid_o); end
      checks++; if (bus.serial_data_o !== exp_d) begin failures++; $display("FAIL b2b_data got=%h exp=%h", bus.serial_data_o, exp_d); end
      pulse_rd();
      checks++; if (bus.serial_ovr_o !== 1'b0) begin failures++; $display("FAIL b2b_ovr_clear got=%b exp=0", bus.serial_ovr_o); end
    end
    checks++; if (bus.serial_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.serial_valid_o); end
  endtask

  task automatic test_abort();
    int r0 = ri_cnt;
    logic [13:0] outs;
    bus.serial_ren_i = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.serial_rxd_i = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    checks++; if (bus.serial_busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", bus.serial_busy_o); end
    bus.serial_ren_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.serial_busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", bus.serial_busy_o); end
    bus.serial_rxd_i = 1'b1;
    wait_ticks(4);
    #1;
    bus.serial_ren_i = 1'b1;
    wait_ticks(OVS * 8);
    @(negedge clk);
    checks++; if (bus.serial_valid_o !== 1'b0 || ri_cnt != r0) begin failures++; $display("FAIL abort_no_write got=%b/%0d exp=0/0", bus.serial_valid_o, ri_cnt - r0); end

    // Load a frame with a framing error, then reset in the middle of the next one.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_ticks(2);
    #1;
    send_bit(1'b0);
    send_bit(1'b1);
    bus.serial_rxd_i = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    checks++; if (bus.serial_valid_o !== 1'b1 || bus.serial_busy_o !== 1'b1 || bus.serial_fe_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid_before got=%b%b%b exp=111", bus.serial_valid_o, bus.serial_busy_o, bus.serial_fe_o);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {bus.serial_busy_o, bus.serial_valid_o, bus.serial_ri_set_o, bus.serial_fe_o,
            bus.serial_ovr_o, bus.serial_rb8_o, bus.serial_data_o};
    checks++; if (outs !== 14'h0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=%h", outs, 14'h0); end
    bus.serial_rxd_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    bus.serial_rxd_i      = 1'b1;
    bus.serial_ren_i      = 1'b1;
    bus.serial_nine_bit_i = 1'b0;
    bus.serial_sm2_i      = 1'b0;
    bus.serial_rd_i       = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_sm2();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
